mac_dot_product_sequencer: RTL and testbench
============================================

Name: mac_dot_product_sequencer

Overview:
- Drives the existing MAC unit (inA/inB 8-bit, clear, clock, outC 19-bit) to compute one element of C = A x B for the 8x8 matrix multiplier.
- On start, it reads row i of A and column j of B from synchronous operand memories and streams the N operand pairs into the MAC.
- It then captures the accumulated sum and presents it with the destination address for the C memory writer.

Parameters:
- N, 8, matrix dimension; number of products accumulated per result.
- DATA_W, 8, operand width; matches MAC inA/inB.
- ACC_W, 19, accumulator width; matches MAC outC. 8*255*255 = 520200 < 2^19, so a result never overflows.
- IDX_W, 3, row/column index width, equal to log2(N).
- ADDR_W, 6, memory address width, equal to 2*IDX_W.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one dot product; sampled only in IDLE.
- row_index  in  IDX_W  row i of A; latched on accepted start.
- col_index  in  IDX_W  column j of B; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- a_addr  out  ADDR_W  A memory read address, row-major: i*N+k.
- b_addr  out  ADDR_W  B memory read address, row-major: k*N+j.
- a_data  in  DATA_W  A memory read data; valid 1 cycle after a_addr.
- b_data  in  DATA_W  B memory read data; valid 1 cycle after b_addr.
- mac_inA  out  DATA_W  to MAC inA.
- mac_inB  out  DATA_W  to MAC inB.
- mac_clear  out  1  to MAC clear.
- mac_outC  in  ACC_W  from MAC outC. The MAC contract is: each rising edge, outC <= clear ? 0 : outC + inA*inB.
- result  out  ACC_W  captured dot product; holds until the next capture.
- c_addr  out  ADDR_W  destination address i*N+j; valid with result_valid.
- result_valid  out  1  one-cycle pulse when result/c_addr are new.

Behaviour:
- States: IDLE -> ISSUE -> DRAIN -> CAPTURE -> DONE -> IDLE.
- Reset values: state IDLE, k=0, busy=0, a_addr=0, b_addr=0, mac_inA=0, mac_inB=0, mac_clear=1, result=0, c_addr=0, result_valid=0.
- IDLE:
  - mac_clear=1 and mac_inA/B=0, holding the MAC accumulator at 0.
  - start=1 latches row_index/col_index, sets k=0, and moves to ISSUE.
- ISSUE (exactly N cycles, k=0..N-1):
  - a_addr=i*N+k, b_addr=k*N+j are registered outputs, valid during the ISSUE cycles.
  - mac_clear=0 from the first ISSUE cycle onward.
  - After k=N-1, go to DRAIN.
- Data path:
  - A data-valid flag is delayed 1 cycle from the address issue.
  - When the flag is set, mac_inA=a_data and mac_inB=b_data.
  - Otherwise mac_inA=mac_inB=0, so the MAC adds 0 and the accumulator holds (the MAC has no enable).
- DRAIN (1 cycle): the last operand pair (k=N-1) is on the MAC inputs. Go to CAPTURE.
- CAPTURE (1 cycle):
  - mac_outC holds the full sum.
  - Register result <= mac_outC and c_addr <= i*N+j.
  - Go to DONE.
- DONE (1 cycle):
  - result_valid=1 and mac_clear=1.
  - Go to IDLE.
- Latency: start sampled in cycle 0 -> result_valid high in cycle N+3 (cycle 11 for N=8). Back-to-back throughput is one result per N+4 cycles.
- Arithmetic: the design does no internal arithmetic on data; ACC_W is sized for worst case, so no saturation or wrap handling is needed. Index math is unsigned with no carry out of ADDR_W.
- start while busy=1 is ignored, including during DONE. The caller must re-assert start in IDLE.
- row_index/col_index changes while busy have no effect on the run in progress.
- reset mid-operation: next cycle state=IDLE, all outputs at reset values. The MAC is re-cleared by mac_clear=1, and no result_valid is emitted for the aborted run.
- A new run starts from a cleared accumulator, because IDLE and DONE both assert mac_clear.

Test Plan:
- A row 0 all 1, B col 0 all 1, start with i=0, j=0 -> result_valid exactly 11 cycles after start, result=8, c_addr=0.
- A row 7 all 255, B col 7 all 255 -> result=520200, c_addr=63, no overflow.
- A row 2 = 1..8, B col 5 all 1 -> result=36, c_addr=21. Verify a_addr sequence 16..23 and b_addr sequence 5,13,...,61.
- Run i=1, j=1 (expected 4), then a second run with different data (expected 10) -> second result is 10, proving the accumulator was cleared between runs. busy is low for at least 1 cycle between runs.
- Pulse start again at cycle 3 of a run with different indices -> ignored: single result_valid, c_addr from the first indices.
- Assert reset in ISSUE at k=4 -> busy=0 and mac_clear=1 next cycle, no result_valid. The following run gives the correct sum.

Source files
------------

// File: rtl/mac_dot_product_sequencer.sv
// Sequencer that computes one element C[i][j] of an NxN matrix product on an
// external MAC unit (outC <= clear ? 0 : outC + inA*inB each rising edge).
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 request one dot product (accepted only when idle)
//   row_index, col_index  i and j, latched when start is accepted
//   busy                  high whenever a run is in progress
//   a_addr, b_addr        operand memory read addresses (i*N+k, k*N+j)
//   a_data, b_data        operand memory read data, one cycle after address
//   mac_inA, mac_inB      operands to the MAC (zero when no data is valid)
//   mac_clear             MAC accumulator clear
//   mac_outC              MAC accumulator value
//   result, c_addr        captured dot product and its destination i*N+j
//   result_valid          one-cycle pulse when result/c_addr are new
module mac_dot_product_sequencer #(
    parameter int unsigned N      = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 19,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  row_index,
    input  logic [IDX_W-1:0]  col_index,
    output logic              busy,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] mac_inA,
    output logic [DATA_W-1:0] mac_inB,
    output logic              mac_clear,
    input  logic [ACC_W-1:0]  mac_outC,
    output logic [ACC_W-1:0]  result,
    output logic [ADDR_W-1:0] c_addr,
    output logic              result_valid
);

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        DRAIN   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } seqState_t;

    seqState_t         state, stateNext;
    logic [IDX_W-1:0]  k, kNext;
    logic [IDX_W-1:0]  rowIdx, rowNext;
    logic [IDX_W-1:0]  colIdx, colNext;
    logic [ADDR_W-1:0] aAddrNext, bAddrNext, cAddrNext;
    logic [ACC_W-1:0]  resultNext;
    logic              dataValid;

    // Row-major flattening of a (row, col) pair into a memory address.
    function automatic logic [ADDR_W-1:0] flatAddr(input logic [IDX_W-1:0] r,
                                                   input logic [IDX_W-1:0] c);
        return ADDR_W'(ADDR_W'(r) * ADDR_W'(N) + ADDR_W'(c));
    endfunction

    // Next-state and next-register values.
    always_comb begin
        stateNext  = state;
        kNext      = k;
        rowNext    = rowIdx;
        colNext    = colIdx;
        aAddrNext  = a_addr;
        bAddrNext  = b_addr;
        resultNext = result;
        cAddrNext  = c_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = ISSUE;
                    kNext     = '0;
                    rowNext   = row_index;
                    colNext   = col_index;
                    aAddrNext = flatAddr(row_index, '0);
                    bAddrNext = flatAddr('0, col_index);
                end
            end
            ISSUE: begin
                if (k == K_LAST) begin
                    stateNext = DRAIN;
                end else begin
                    kNext     = k + IDX_W'(1);
                    aAddrNext = flatAddr(rowIdx, k + IDX_W'(1));
                    bAddrNext = flatAddr(k + IDX_W'(1), colIdx);
                end
            end
            DRAIN: stateNext = CAPTURE;
            CAPTURE: begin
                stateNext  = DONE;
                resultNext = mac_outC;
                cAddrNext  = flatAddr(rowIdx, colIdx);
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State and registered outputs; status outputs are decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            k            <= '0;
            rowIdx       <= '0;
            colIdx       <= '0;
            a_addr       <= '0;
            b_addr       <= '0;
            result       <= '0;
            c_addr       <= '0;
            busy         <= 1'b0;
            mac_clear    <= 1'b1;
            result_valid <= 1'b0;
            dataValid    <= 1'b0;
        end else begin
            state        <= stateNext;
            k            <= kNext;
            rowIdx       <= rowNext;
            colIdx       <= colNext;
            a_addr       <= aAddrNext;
            b_addr       <= bAddrNext;
            result       <= resultNext;
            c_addr       <= cAddrNext;
            busy         <= (stateNext != IDLE);
            mac_clear    <= (stateNext == IDLE) || (stateNext == DONE);
            result_valid <= (stateNext == DONE);
            // Memory data lags the address by one cycle.
            dataValid    <= (state == ISSUE);
        end
    end

    // Zero operands outside the data window so the MAC accumulator holds.
    assign mac_inA = dataValid ? a_data : '0;
    assign mac_inB = dataValid ? b_data : '0;

endmodule

// File: tb/tb_mac_dot_product_sequencer.sv
// Bench for mac_dot_product_sequencer: operand memories and a MAC around the
// DUT, a cycle-count model of the expected outputs, and directed runs.
module tb_mac_dot_product_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  row_index, col_index;
    logic        busy;
    logic [5:0]  a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic [7:0]  mac_inA, mac_inB;
    logic        mac_clear;
    logic [18:0] mac_outC;
    logic [18:0] result;
    logic [5:0]  c_addr;
    logic        result_valid;

    logic [7:0] memA [64];
    logic [7:0] memB [64];

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // Model state: cnt = cycles since the accepted start (0 = idle).
    int cnt = 0;
    int mi = 0, mj = 0, expSum = 0;
    int heldRes = 0, heldC = 0;

    mac_dot_product_sequencer dut (
        .clock(clock), .reset(reset), .start(start),
        .row_index(row_index), .col_index(col_index), .busy(busy),
        .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
        .mac_inA(mac_inA), .mac_inB(mac_inB), .mac_clear(mac_clear),
        .mac_outC(mac_outC), .result(result), .c_addr(c_addr),
        .result_valid(result_valid)
    );

    always #5 clock = ~clock;

    // Synchronous operand memories and the MAC unit.
    always @(posedge clock) begin
        a_data   <= memA[a_addr];
        b_data   <= memB[b_addr];
        mac_outC <= mac_clear ? 19'd0 : mac_outC + 19'(mac_inA) * 19'(mac_inB);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dotRef(input int i, input int j);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(memA[i*8+k]) * int'(memB[k*8+j]);
        return s;
    endfunction

    // Behavioural model: timeline of a run counted from the accepting edge.
    always @(posedge clock) begin
        if (reset) begin
            cnt = 0; heldRes = 0; heldC = 0;
        end else if (cnt == 0) begin
            if (start) begin
                mi = int'(row_index); mj = int'(col_index);
                expSum = dotRef(mi, mj);
                cnt = 1;
            end
        end else begin
            cnt++;
            if (cnt == 11) begin heldRes = expSum; heldC = mi*8 + mj; end
            if (cnt == 12) cnt = 0;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clock) begin
        if (checkEn) begin
            int expA, expB;
            chk("busy", int'(busy), int'(cnt != 0));
            chk("result_valid", int'(result_valid), int'(cnt == 11));
            chk("mac_clear", int'(mac_clear), int'(cnt == 0 || cnt == 11));
            chk("result", int'(result), heldRes);
            chk("c_addr", int'(c_addr), heldC);
            if (cnt >= 1 && cnt <= 8) begin
                chk("a_addr", int'(a_addr), mi*8 + cnt - 1);
                chk("b_addr", int'(b_addr), (cnt-1)*8 + mj);
            end
            expA = (cnt >= 2 && cnt <= 9) ? int'(memA[mi*8 + cnt - 2]) : 0;
            expB = (cnt >= 2 && cnt <= 9) ? int'(memB[(cnt-2)*8 + mj]) : 0;
            chk("mac_inA", int'(mac_inA), expA);
            chk("mac_inB", int'(mac_inB), expB);
        end
    end

    // One run starting at the current negedge; returns cycles to result_valid
    // (0 on timeout). Optionally pulses a second start at cycle 3.
    task automatic runOnce(input int i, input int j, input bit glitch, output int lat);
        lat = 0;
        start = 1'b1; row_index = 3'(i); col_index = 3'(j);
        @(posedge clock);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clock);
            start = 1'b0;
            if (glitch && n == 3) begin
                start = 1'b1; row_index = 3'd4; col_index = 3'd6;
            end
            if (result_valid) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic countValids(input int cycles, output int v);
        v = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock);
            if (result_valid) v++;
        end
    endtask

    initial begin
        int lat, v;
        reset = 1'b1; start = 1'b0; row_index = '0; col_index = '0;
        for (int a = 0; a < 64; a++) begin
            memA[a] = 8'((a * 7 + 3) & 255);
            memB[a] = 8'((a * 13 + 5) & 255);
        end
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_a_addr", int'(a_addr), 0);
        chk("rst_b_addr", int'(b_addr), 0);
        chk("rst_mac_inA", int'(mac_inA), 0);
        chk("rst_mac_clear", int'(mac_clear), 1);
        chk("rst_result", int'(result), 0);
        chk("rst_result_valid", int'(result_valid), 0);
        reset = 1'b0;
        checkEn = 1'b1;
        @(negedge clock);

        // Row 0 of ones against column 0 of ones.
        for (int k = 0; k < 8; k++) begin memA[k] = 8'd1; memB[k*8] = 8'd1; end
        runOnce(0, 0, 1'b0, lat);
        chk("t1_latency", lat, 11);
        chk("t1_result", int'(result), 8);
        chk("t1_c_addr", int'(c_addr), 0);
        @(negedge clock);

        // Worst case operands.
        for (int k = 0; k < 8; k++) begin memA[56+k] = 8'd255; memB[k*8+7] = 8'd255; end
        runOnce(7, 7, 1'b0, lat);
        chk("t2_result", int'(result), 520200);
        chk("t2_c_addr", int'(c_addr), 63);
        @(negedge clock);

        // Ramp row against ones column; address sequences checked per cycle.
        for (int k = 0; k < 8; k++) begin memA[16+k] = 8'(k + 1); memB[k*8+5] = 8'd1; end
        runOnce(2, 5, 1'b0, lat);
        chk("t3_result", int'(result), 36);
        chk("t3_c_addr", int'(c_addr), 21);
        @(negedge clock);

        // Back-to-back runs: accumulator must restart from zero.
        for (int k = 0; k < 8; k++) begin memA[8+k] = (k < 4) ? 8'd1 : 8'd0; memB[k*8+1] = 8'd1; end
        runOnce(1, 1, 1'b0, lat);
        chk("t4a_result", int'(result), 4);
        @(negedge clock);
        chk("t4_gap_busy", int'(busy), 0);
        for (int k = 0; k < 8; k++) memA[8+k] = (k < 4) ? 8'(k + 1) : 8'd0;
        runOnce(1, 1, 1'b0, lat);
        chk("t4b_result", int'(result), 10);
        @(negedge clock);

        // A start while busy is ignored.
        for (int k = 0; k < 8; k++) begin memA[24+k] = 8'd2; memB[k*8+2] = 8'd3; end
        runOnce(3, 2, 1'b1, lat);
        chk("t5_latency", lat, 11);
        chk("t5_result", int'(result), 48);
        chk("t5_c_addr", int'(c_addr), 26);
        countValids(14, v);
        chk("t5_extra_valids", v, 0);

        // Reset during ISSUE at k=4 aborts the run without a result.
        start = 1'b1; row_index = 3'd2; col_index = 3'd5;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_mac_clear", int'(mac_clear), 1);
        countValids(14, v);
        chk("t6_no_valid", v, 0);
        runOnce(2, 5, 1'b0, lat);
        chk("t6_rerun_latency", lat, 11);
        chk("t6_rerun_result", int'(result), 36);
        repeat (3) @(negedge clock);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
